spi_slave_regfile: RTL and testbench



---
 rtl/spi_slave_regfile.sv | 241 ++++++++++++++++++++++++
 tb/tb_spi_slave_regfile.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regfile.sv
// spi_slave_regfile: SPI mode-0 responder exposing a bank of 8-bit registers.
// Frame is 16 bits, MSB first: {rw, addr[6:0], data[7:0]}; rw=1 reads.
// SCK, CSN and MOSI are oversampled in the sys_clk domain (sys_clk >= 8x SCK).
// Optional build macro: SPI_SLV_ERR_CNT_EN adds an 8-bit saturating abort
// counter readable at address 0x7F and cleared by any write to 0x7F
// (requires REG_NUM <= 127).
module spi_slave_regfile #(
   parameter int         REG_NUM     = 16,
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] RST_VAL     = 8'h00
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 spi_csn,
   input  logic                 spi_sck,
   input  logic                 spi_mosi,
   output logic                 spi_miso,
   output logic                 spi_miso_oe,
   output logic                 reg_wr_stb,
   output logic [6:0]           reg_wr_addr,
   output logic [REG_NUM*8-1:0] reg_q
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CMD,
      ST_DATA,
      ST_DONE
   } state_t;

   localparam logic [7:0] REG_NUM_B = 8'(REG_NUM);

   // synchronisers and edge-detect history
   logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0] csn_sync_q, csn_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sck_prev_q, sck_prev_d;
   logic                   csn_prev_q, csn_prev_d;

   // frame state
   state_t     state_q, state_d;
   logic [4:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] rx_shift_q, rx_shift_d;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic       rw_q, rw_d;
   logic [6:0] addr_q, addr_d;
   logic       wr_pend_q, wr_pend_d;

   // registered outputs and register bank
   logic       miso_q, miso_d;
   logic       miso_oe_q, miso_oe_d;
   logic       wr_stb_q, wr_stb_d;
   logic [6:0] wr_addr_q, wr_addr_d;
   logic [7:0] regs_q [REG_NUM];
   logic [7:0] regs_d [REG_NUM];

`ifdef SPI_SLV_ERR_CNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;
`endif

   // decoded edges and the command fields as they complete on the 8th bit
   logic       sck_s, csn_s, mosi_s;
   logic       sck_rise, sck_fall, csn_rise, csn_fall;
   logic [6:0] addr_new;
   logic [7:0] rd_data;
   logic       wr_in_range;

   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign csn_s    = csn_sync_q[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s & sck_prev_q;
   assign csn_rise = csn_s & ~csn_prev_q;
   assign csn_fall = ~csn_s & csn_prev_q;
   assign addr_new = {rx_shift_q[5:0], mosi_s};
   assign wr_in_range = ({1'b0, addr_q} < REG_NUM_B);

   // Read mux for the address being completed; unimplemented addresses read 0
   always_comb begin
      rd_data = 8'h00;
      for (int i = 0; i < REG_NUM; i++) begin
         if (addr_new == 7'(i)) rd_data = regs_q[i];
      end
`ifdef SPI_SLV_ERR_CNT_EN
      if (addr_new == 7'h7F) rd_data = err_cnt_q;
`endif
   end

   // Next-state logic: synchronisers, write commit, frame FSM
   always_comb begin
      sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      csn_sync_d  = {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sck_prev_d  = sck_s;
      csn_prev_d  = csn_s;

      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      rx_shift_d = rx_shift_q;
      tx_shift_d = tx_shift_q;
      rw_d       = rw_q;
      addr_d     = addr_q;
      wr_pend_d  = 1'b0;
      miso_d     = miso_q;
      miso_oe_d  = miso_oe_q;
      wr_stb_d   = 1'b0;
      wr_addr_d  = wr_addr_q;
      regs_d     = regs_q;
`ifdef SPI_SLV_ERR_CNT_EN
      err_cnt_d  = err_cnt_q;
`endif

      // Commit a completed write one cycle after the 16th bit; this is
      // independent of CSN so a quick deselect cannot lose a full frame.
      if (wr_pend_q) begin
         if (wr_in_range) begin
            for (int i = 0; i < REG_NUM; i++) begin
               if (addr_q == 7'(i)) regs_d[i] = rx_shift_q;
            end
            wr_stb_d  = 1'b1;
            wr_addr_d = addr_q;
         end
`ifdef SPI_SLV_ERR_CNT_EN
         else if (addr_q == 7'h7F) begin
            err_cnt_d = 8'h00;
         end
`endif
      end

      // CSN rising wins over any SCK edge seen in the same cycle
      if (csn_rise) begin
`ifdef SPI_SLV_ERR_CNT_EN
         if (bit_cnt_q != 5'd0 && bit_cnt_q < 5'd16 && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end
`endif
         state_d   = ST_IDLE;
         bit_cnt_d = 5'd0;
         miso_d    = 1'b0;
         miso_oe_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (csn_fall) begin
                  state_d   = ST_CMD;
                  bit_cnt_d = 5'd0;
                  miso_d    = 1'b0;
                  miso_oe_d = 1'b1;
               end
            end
            ST_CMD, ST_DATA: begin
               if (sck_rise) begin
                  rx_shift_d = {rx_shift_q[6:0], mosi_s};
                  bit_cnt_d  = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd7) begin
                     rw_d       = rx_shift_q[6];
                     addr_d     = addr_new;
                     tx_shift_d = rx_shift_q[6] ? rd_data : 8'h00;
                     state_d    = ST_DATA;
                  end
                  if (bit_cnt_q == 5'd15) begin
                     wr_pend_d = ~rw_q;
                     state_d   = ST_DONE;
                  end
               end else if (sck_fall && state_q == ST_DATA) begin
                  // falling edges 8..15 present data bits 7..0
                  miso_d     = tx_shift_q[7];
                  tx_shift_d = {tx_shift_q[6:0], 1'b0};
               end
            end
            ST_DONE: begin
               miso_d = 1'b0;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         sck_sync_q  <= '0;
         // CSN history resets low so a CSN already low at reset release is
         // not mistaken for a new select; a fresh high/low cycle is needed.
         csn_sync_q  <= '0;
         mosi_sync_q <= '0;
         sck_prev_q  <= 1'b0;
         csn_prev_q  <= 1'b0;
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 5'd0;
         rx_shift_q  <= 8'h00;
         tx_shift_q  <= 8'h00;
         rw_q        <= 1'b0;
         addr_q      <= 7'd0;
         wr_pend_q   <= 1'b0;
         miso_q      <= 1'b0;
         miso_oe_q   <= 1'b0;
         wr_stb_q    <= 1'b0;
         wr_addr_q   <= 7'd0;
         for (int i = 0; i < REG_NUM; i++) regs_q[i] <= RST_VAL;
`ifdef SPI_SLV_ERR_CNT_EN
         err_cnt_q   <= 8'h00;
`endif
      end else begin
         sck_sync_q  <= sck_sync_d;
         csn_sync_q  <= csn_sync_d;
         mosi_sync_q <= mosi_sync_d;
         sck_prev_q  <= sck_prev_d;
         csn_prev_q  <= csn_prev_d;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         rw_q        <= rw_d;
         addr_q      <= addr_d;
         wr_pend_q   <= wr_pend_d;
         miso_q      <= miso_d;
         miso_oe_q   <= miso_oe_d;
         wr_stb_q    <= wr_stb_d;
         wr_addr_q   <= wr_addr_d;
         regs_q      <= regs_d;
`ifdef SPI_SLV_ERR_CNT_EN
         err_cnt_q   <= err_cnt_d;
`endif
      end
   end

   assign spi_miso    = miso_q;
   assign spi_miso_oe = miso_oe_q;
   assign reg_wr_stb  = wr_stb_q;
   assign reg_wr_addr = wr_addr_q;

   generate
      for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_reg_out
         assign reg_q[8*gi +: 8] = regs_q[gi];
      end
   endgenerate

endmodule

// File: tb/tb_spi_slave_regfile.sv
// tb_spi_slave_regfile: scoreboard bench for spi_slave_regfile.
// Writes push expected strobes, reads push expected bytes; a monitor pops
// strobes, and each test pops read results. Honours SPI_SLV_ERR_CNT_EN.
module tb_spi_slave_regfile;

   localparam int         REG_NUM = 16;
   localparam int         SS      = 2;
   localparam int         HALF    = 8;
   localparam int         GAP     = 12;
   localparam logic [7:0] RST_VAL = 8'h00;

   logic                 sys_clk = 1'b0;
   logic                 sys_rst_n = 1'b0;
   logic                 spi_csn = 1'b1;
   logic                 spi_sck = 1'b0;
   logic                 spi_mosi = 1'b0;
   logic                 spi_miso;
   logic                 spi_miso_oe;
   logic                 reg_wr_stb;
   logic [6:0]           reg_wr_addr;
   logic [REG_NUM*8-1:0] reg_q;

   spi_slave_regfile #(
      .REG_NUM     (REG_NUM),
      .SYNC_STAGES (SS),
      .RST_VAL     (RST_VAL)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .spi_csn     (spi_csn),
      .spi_sck     (spi_sck),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .spi_miso_oe (spi_miso_oe),
      .reg_wr_stb  (reg_wr_stb),
      .reg_wr_addr (reg_wr_addr),
      .reg_q       (reg_q)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic [6:0] addr;
      logic [7:0] data;
   } wr_t;

   int         vectors = 0;
   int         miscompares = 0;
   int         cyc_cnt = 0;
   int         sck16_cyc = 0;
   int         err_exp = 0;
   wr_t        exp_wr[$];
   logic [7:0] exp_rd[$];
   logic [7:0] model [REG_NUM];

   always @(posedge sys_clk) cyc_cnt <= cyc_cnt + 1;

   // watchdog
   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   // strobe monitor: pops the expected-write queue on each reg_wr_stb
   initial begin
      forever begin
         @(negedge sys_clk);
         if (reg_wr_stb === 1'b1) begin
            if (exp_wr.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_strobe: got strobe addr=0x%02h, expected no strobe", reg_wr_addr);
            end else begin
               wr_t e;
               int  a;
               e = exp_wr.pop_front();
               a = int'(e.addr);
               vectors++;
               if (reg_wr_addr !== e.addr) begin
                  miscompares++;
                  $display("FAIL strobe_addr: got 0x%02h, expected 0x%02h", reg_wr_addr, e.addr);
               end
               vectors++;
               if (reg_q[8*a +: 8] !== e.data) begin
                  miscompares++;
                  $display("FAIL strobe_data: reg 0x%02h got 0x%02h, expected 0x%02h", e.addr, reg_q[8*a +: 8], e.data);
               end
               vectors++;
               if (cyc_cnt != sck16_cyc + SS + 2) begin
                  miscompares++;
                  $display("FAIL strobe_latency: got %0d cycles, expected %0d", cyc_cnt - sck16_cyc, SS + 2);
               end
               $display("strobe: addr=0x%02h data=0x%02h", reg_wr_addr, reg_q[8*a +: 8]);
            end
         end
      end
   end

   // One SPI frame as the PS master would drive it; pushes expectations.
   task automatic send(input logic rw, input logic [6:0] addr, input logic [7:0] data,
                       input int nsck, input int gap, output logic [7:0] rd, output int bad);
      logic [15:0] word;
      logic [7:0]  e;
      int          ai;
      word = {rw, addr, data};
      ai   = int'(addr);
      rd   = 8'h00;
      bad  = 0;
      if (nsck >= 16) begin
         if (!rw && addr < REG_NUM) begin
            exp_wr.push_back('{addr, data});
            model[ai] = data;
         end
         if (!rw && addr == 7'h7F) err_exp = 0;
         if (rw) begin
            e = (addr < REG_NUM) ? model[ai] : 8'h00;
`ifdef SPI_SLV_ERR_CNT_EN
            if (addr == 7'h7F) e = 8'(err_exp);
`endif
            exp_rd.push_back(e);
         end
      end else if (nsck > 0 && err_exp < 255) begin
         err_exp++;
      end
      @(negedge sys_clk);
      spi_csn = 1'b0;
      repeat (HALF) @(negedge sys_clk);
      for (int b = 0; b < nsck; b++) begin
         spi_mosi = (b < 16) ? word[15-b] : 1'b0;
         repeat (HALF) @(negedge sys_clk);
         if (b >= 8 && b < 16) rd = {rd[6:0], spi_miso};
         else if (spi_miso !== 1'b0) bad++;
         if (spi_miso_oe !== 1'b1) bad++;
         spi_sck = 1'b1;
         if (b == 15) sck16_cyc = cyc_cnt;
         repeat (HALF) @(negedge sys_clk);
         spi_sck = 1'b0;
      end
      repeat (HALF) @(negedge sys_clk);
      spi_csn = 1'b1;
      repeat (gap) @(negedge sys_clk);
      $display("frame: rw=%0d addr=0x%02h data=0x%02h sck=%0d miso_byte=0x%02h", rw, addr, data, nsck, rd);
   endtask

   task automatic test_reset();
      logic [REG_NUM*8-1:0] flat;
      logic [7:0]           rd, e;
      int                   bad;
      for (int i = 0; i < REG_NUM; i++) model[i] = RST_VAL;
      for (int i = 0; i < REG_NUM; i++) flat[8*i +: 8] = RST_VAL;
      sys_rst_n = 1'b0;
      repeat (5) @(negedge sys_clk);
      vectors++;
      if ({spi_miso, spi_miso_oe, reg_wr_stb, reg_wr_addr} !== 10'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got miso=%b oe=%b stb=%b addr=0x%02h, expected all 0",
                  spi_miso, spi_miso_oe, reg_wr_stb, reg_wr_addr);
      end
      vectors++;
      if (reg_q !== flat) begin
         miscompares++;
         $display("FAIL reset_regs: got 0x%h, expected 0x%h", reg_q, flat);
      end
      sys_rst_n = 1'b1;
      repeat (5) @(negedge sys_clk);
      send(1'b1, 7'h03, 8'h00, 16, GAP, rd, bad);
      e = exp_rd.pop_front();
      vectors++;
      if (rd !== e) begin
         miscompares++;
         $display("FAIL reset_read03: got 0x%02h, expected 0x%02h", rd, e);
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL reset_read_miso: got %0d bad MISO/OE samples, expected 0", bad);
      end
   endtask

   task automatic test_write_read();
      logic [7:0] rd, e;
      int         bad;
      send(1'b0, 7'h05, 8'hA5, 16, GAP, rd, bad);
      vectors++;
      if (reg_q[47:40] !== 8'hA5) begin
         miscompares++;
         $display("FAIL wr_reg05: got 0x%02h, expected 0xa5", reg_q[47:40]);
      end
      send(1'b1, 7'h05, 8'h00, 16, GAP, rd, bad);
      e = exp_rd.pop_front();
      vectors++;
      if (rd !== e) begin
         miscompares++;
         $display("FAIL rd_reg05: got 0x%02h, expected 0x%02h", rd, e);
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL rd_reg05_miso: got %0d bad MISO/OE samples, expected 0", bad);
      end
   endtask

   task automatic test_out_of_range();
      logic [REG_NUM*8-1:0] snap;
      logic [7:0]           rd, e;
      int                   bad;
      snap = reg_q;
      send(1'b0, 7'h20, 8'h5A, 16, GAP, rd, bad);
      vectors++;
      if (reg_q !== snap) begin
         miscompares++;
         $display("FAIL oor_regs: got 0x%h, expected 0x%h", reg_q, snap);
      end
      send(1'b1, 7'h20, 8'h00, 16, GAP, rd, bad);
      e = exp_rd.pop_front();
      vectors++;
      if (rd !== e) begin
         miscompares++;
         $display("FAIL oor_read: got 0x%02h, expected 0x%02h", rd, e);
      end
   endtask

   task automatic test_abort();
      logic [7:0] rd, e;
      int         bad;
      send(1'b0, 7'h02, 8'hC3, 11, GAP, rd, bad);
      vectors++;
      if (reg_q[23:16] !== model[2]) begin
         miscompares++;
         $display("FAIL abort_reg02: got 0x%02h, expected 0x%02h", reg_q[23:16], model[2]);
      end
      send(1'b1, 7'h7F, 8'h00, 16, GAP, rd, bad);
      e = exp_rd.pop_front();
      vectors++;
      if (rd !== e) begin
         miscompares++;
         $display("FAIL abort_cnt_read: got 0x%02h, expected 0x%02h", rd, e);
      end
      send(1'b0, 7'h7F, 8'h99, 16, GAP, rd, bad);
      send(1'b1, 7'h7F, 8'h00, 16, GAP, rd, bad);
      e = exp_rd.pop_front();
      vectors++;
      if (rd !== e) begin
         miscompares++;
         $display("FAIL abort_cnt_clear: got 0x%02h, expected 0x%02h", rd, e);
      end
   endtask

   task automatic test_long_frame();
      logic [7:0] rd;
      int         bad;
      send(1'b0, 7'h01, 8'h3C, 24, GAP, rd, bad);
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL long_miso: got %0d nonzero MISO/OE samples, expected 0", bad);
      end
      vectors++;
      if (reg_q[15:8] !== 8'h3C) begin
         miscompares++;
         $display("FAIL long_reg01: got 0x%02h, expected 0x3c", reg_q[15:8]);
      end
   endtask

   task automatic test_reset_midframe();
      logic [15:0] word;
      logic [7:0]  rd, e;
      int          bad;
      send(1'b0, 7'h04, 8'h77, 16, GAP, rd, bad);
      vectors++;
      if (reg_q[39:32] !== 8'h77) begin
         miscompares++;
         $display("FAIL mid_pre_reg04: got 0x%02h, expected 0x77", reg_q[39:32]);
      end
      word = {1'b0, 7'h04, 8'hE1};
      @(negedge sys_clk);
      spi_csn = 1'b0;
      repeat (HALF) @(negedge sys_clk);
      for (int b = 0; b < 16; b++) begin
         if (b == 12) begin
            sys_rst_n = 1'b0;
            repeat (4) @(negedge sys_clk);
            sys_rst_n = 1'b1;
            for (int i = 0; i < REG_NUM; i++) model[i] = RST_VAL;
            err_exp = 0;
            vectors++;
            if (reg_q[39:32] !== RST_VAL) begin
               miscompares++;
               $display("FAIL mid_reset_reg04: got 0x%02h, expected 0x%02h", reg_q[39:32], RST_VAL);
            end
         end
         spi_mosi = word[15-b];
         repeat (HALF) @(negedge sys_clk);
         spi_sck = 1'b1;
         repeat (HALF) @(negedge sys_clk);
         spi_sck = 1'b0;
      end
      repeat (HALF) @(negedge sys_clk);
      vectors++;
      if (spi_miso_oe !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_oe_after_reset: got %b, expected 0", spi_miso_oe);
      end
      spi_csn = 1'b1;
      repeat (GAP) @(negedge sys_clk);
      $display("frame: reset during data byte of write 0x04 <- 0xe1");
      vectors++;
      if (reg_q[39:32] !== RST_VAL) begin
         miscompares++;
         $display("FAIL mid_post_reg04: got 0x%02h, expected 0x%02h", reg_q[39:32], RST_VAL);
      end
      send(1'b0, 7'h04, 8'h5A, 16, GAP, rd, bad);
      send(1'b1, 7'h04, 8'h00, 16, GAP, rd, bad);
      e = exp_rd.pop_front();
      vectors++;
      if (rd !== e) begin
         miscompares++;
         $display("FAIL mid_next_frame: got 0x%02h, expected 0x%02h", rd, e);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] rd, e;
      int         bad;
      send(1'b0, 7'h0A, 8'h11, 16, 4, rd, bad);
      send(1'b0, 7'h0B, 8'h22, 16, 4, rd, bad);
      send(1'b1, 7'h0A, 8'h00, 16, 4, rd, bad);
      e = exp_rd.pop_front();
      vectors++;
      if (rd !== e) begin
         miscompares++;
         $display("FAIL b2b_read0a: got 0x%02h, expected 0x%02h", rd, e);
      end
      send(1'b1, 7'h0B, 8'h00, 16, GAP, rd, bad);
      e = exp_rd.pop_front();
      vectors++;
      if (rd !== e) begin
         miscompares++;
         $display("FAIL b2b_read0b: got 0x%02h, expected 0x%02h", rd, e);
      end
   endtask

   initial begin
      logic [REG_NUM*8-1:0] flat;
      test_reset();
      test_write_read();
      test_out_of_range();
      test_abort();
      test_long_frame();
      test_reset_midframe();
      test_back_to_back();
      repeat (20) @(negedge sys_clk);
      vectors++;
      if (exp_wr.size() != 0) begin
         miscompares++;
         $display("FAIL missing_strobes: got %0d writes without strobe, expected 0", exp_wr.size());
      end
      for (int i = 0; i < REG_NUM; i++) flat[8*i +: 8] = model[i];
      vectors++;
      if (reg_q !== flat) begin
         miscompares++;
         $display("FAIL final_regs: got 0x%h, expected 0x%h", reg_q, flat);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
